module_teclado_scan: RTL
========================

# module_teclado_scan

Scanner for a 4x4 matrix keypad that produces the 4-bit key bus `B` consumed by `module_evaluar`. It drives one keypad row low at a time and reads the columns through a synchronizer. It debounces both press and release, and holds `B` at a non-zero key code for exactly as long as a key is stably pressed. `B` is `4'b0000` whenever no key is held, so `module_evaluar` sees exactly one 0 to non-0 edge per key press.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each row stays driven while scanning; must be at least 4.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a press or a release; must be at least 2.
- `clk`  in  1  system clock; the block's only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `col_i`  in  4  keypad columns, active-low, externally pulled up, asynchronous.
- `row_o`  out  4  keypad rows, active-low, exactly one bit low at all times.
- `B`  out  4  key code; 0 means no key pressed.

## Operation
- Input sync: `col_i` passes through a 2-FF synchronizer into `col_s`. All decisions use `col_s`.
- Row index `r` (0..3) and column index `c` (0..3) identify a key.
  - `row_o` equals ~(1<<r).
  - Key code is `r*4 + c + 1`, giving values 1..15.
  - Key r=3, c=3 is reserved and treated as "no key".
- A column pattern is valid when exactly one bit of `col_s` is 0 and it does not select the reserved key. Any other non-`4'hF` pattern (two or more columns low) is treated as no key.
- States:
  - SCAN:
    - `div_cnt` counts 0..`SCAN_DIV`-1.
    - At `div_cnt` == `SCAN_DIV`-1, sample `col_s`.
    - Valid pattern: capture it in `col_cap`, clear `deb_cnt`, go to DEBOUNCE. The row is not advanced.
    - Otherwise: advance `r` = (r+1) mod 4 and clear `div_cnt`.
  - DEBOUNCE:
    - `row_o` is held.
    - Each cycle `col_s` == `col_cap`: `deb_cnt`++.
    - When `deb_cnt` reaches `DEBOUNCE_CYCLES`-1, go to PRESSED and register `B` <= code.
    - On any mismatch: go to SCAN, advance `r`, clear `div_cnt`. `B` stays 0.
  - PRESSED:
    - `row_o` and `B` are held.
    - When `col_s` == `4'hF`, go to RELEASE with `deb_cnt` = 0.
    - Any other change of `col_s` is ignored; the key stays registered until a full release.
  - RELEASE:
    - `B` is held.
    - Each cycle `col_s` == `4'hF`: `deb_cnt`++.
    - When `deb_cnt` reaches `DEBOUNCE_CYCLES`-1: `B` <= 0, go to SCAN, advance `r`, clear `div_cnt`.
    - Any column low: return to PRESSED, `B` unchanged.
- Counters are sized $clog2 of their parameter, and they saturate by construction (state exits at terminal count).

## Timing
- Reset values:
  - `row_o` = `4'b1110` (r=0), `B` = `4'b0000`, state SCAN.
  - `div_cnt`, `deb_cnt` and `col_cap` = 0; synchronizer flops = `4'hF`.
- Reset mid-operation (any state) returns to these values on the next clock edge. `B` drops to 0 that edge, with no release debounce.
- Press latency: a key held steadily from before its row's sample point gives `B` = code `DEBOUNCE_CYCLES`+1 cycles after the SCAN sample edge.
  - 1 cycle goes to the state change.
  - `DEBOUNCE_CYCLES` cycles go to counting, including the registered `B` update.
- Release latency: `B` returns to 0 `DEBOUNCE_CYCLES`+3 cycles after `col_i` returns to `4'hF`, counting 2 sync cycles.
- Row settling: `SCAN_DIV` >= 4 guarantees at least 3 cycles between a row change and its sample edge, which covers synchronizer latency.
- Worst-case detection delay before debounce starts is 4*`SCAN_DIV` cycles, one full row rotation.
- `B` changes only on entry to PRESSED (0 to code) and exit from RELEASE (code to 0). It never changes directly from one non-zero code to another.

## Test plan
Bench parameters are `SCAN_DIV`=4 and `DEBOUNCE_CYCLES`=8. The keypad model pulls column c low while key (r,c) is "pressed" and `row_o`[r]=0.
- Reset: hold `rst_n`=0 for 3 cycles with no keys.
  - Required: `row_o`=`1110` and `B`=0.
  - After release of reset, `row_o` rotates 1110, 1101, 1011, 0111, 1110, one step every 4 cycles.
- Clean press and release of key (1,2):
  - Required: `B` goes from 0 to 7 exactly 9 cycles after the row-1 sample edge, and `row_o` is frozen at `1101`.
  - Release: `B` returns to 0 exactly 11 cycles after `col_i` goes `4'hF`, then scanning resumes at row 2.
- Bounce: press key (0,0) and toggle `col_i`[0] every 3 cycles for 20 cycles, then hold it low.
  - Required: `B` stays 0 during the bounce and becomes 1 only after 8 stable cycles.
  - Release bounce of the same kind: `B` holds 1 until a stable release completes.
- Invalid patterns: press keys (2,0) and (2,1) together, then the reserved key (3,3) alone.
  - Required: `B` stays 0 and `row_o` keeps rotating for at least 64 cycles.
- Reset mid-press: while `B`=7, pulse `rst_n`=0 for 1 cycle.
  - Required: `B`=0 and `row_o`=`1110` on the next edge.
  - With the key still held, `B`=7 again after a normal detection and debounce.
- Integration with `module_evaluar`: press key 5, release, then press key 15.
  - Required: `start` pulses exactly once per press, and never during a hold or release.

Source files
------------

// File: rtl/module_teclado_scan_if.sv
// Keypad bus: column inputs from the matrix, row drive back to it, and the key code
// handed to the evaluator.
interface module_teclado_scan_if;
   logic [3:0] col_i;
   logic [3:0] row_o;
   logic [3:0] B;

   modport master (output col_i, input row_o, input B);
   modport slave  (input col_i, output row_o, output B);
endinterface

// File: rtl/module_teclado_scan.sv
// 4x4 keypad scanner: rotates an active-low row, debounces press and release,
// and holds a non-zero key code on B only while a key is stably pressed.
module module_teclado_scan #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                clk,
   input  logic                rst_n,
   module_teclado_scan_if.slave kp
);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   state_t           state_r, state_s;
   logic [3:0]       sync1_r, col_s_r;
   logic [DIV_W-1:0] div_r, div_s;
   logic [DEB_W-1:0] deb_r, deb_s;
   logic [1:0]       row_idx_r, row_idx_s;
   logic [3:0]       row_r, row_s;
   logic [3:0]       col_cap_r, col_cap_s;
   logic [3:0]       key_r, key_s;
   logic             valid_s;

   // Exactly one column low, and not the reserved bottom-right key.
   function automatic logic pattern_valid(input logic [3:0] col, input logic [1:0] r);
      logic ok;
      case (col)
         4'b1110, 4'b1101, 4'b1011: ok = 1'b1;
         4'b0111:                   ok = (r != 2'd3);
         default:                   ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [3:0] col);
      logic [1:0] c;
      case (col)
         4'b1110: c = 2'd0;
         4'b1101: c = 2'd1;
         4'b1011: c = 2'd2;
         default: c = 2'd3;
      endcase
      return {r, c} + 4'd1;
   endfunction

   assign valid_s  = pattern_valid(col_s_r, row_idx_r);
   assign kp.row_o = row_r;
   assign kp.B     = key_r;

   // Two-flop synchronizer for the asynchronous column lines
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_r <= 4'hF;
         col_s_r <= 4'hF;
      end else begin
         sync1_r <= kp.col_i;
         col_s_r <= sync1_r;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_SCAN;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decision
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_SCAN: begin
            if ((div_r == DIV_LAST) && valid_s) state_s = ST_DEBOUNCE;
            else                                state_s = ST_SCAN;
         end
         ST_DEBOUNCE: begin
            if (col_s_r != col_cap_r)   state_s = ST_SCAN;
            else if (deb_r == DEB_LAST) state_s = ST_PRESSED;
            else                        state_s = ST_DEBOUNCE;
         end
         ST_PRESSED: begin
            if (col_s_r == 4'hF) state_s = ST_RELEASE;
            else                 state_s = ST_PRESSED;
         end
         ST_RELEASE: begin
            if (col_s_r != 4'hF)        state_s = ST_PRESSED;
            else if (deb_r == DEB_LAST) state_s = ST_SCAN;
            else                        state_s = ST_RELEASE;
         end
         default: state_s = ST_SCAN;
      endcase
   end

   // Counter, row, capture and key-code updates for each state
   always_comb begin
      div_s     = div_r;
      deb_s     = deb_r;
      row_idx_s = row_idx_r;
      col_cap_s = col_cap_r;
      key_s     = key_r;
      case (state_r)
         ST_SCAN: begin
            if (div_r != DIV_LAST) begin
               div_s = div_r + DIV_W'(1);
            end else if (valid_s) begin
               col_cap_s = col_s_r;
               deb_s     = '0;
            end else begin
               row_idx_s = row_idx_r + 2'd1;
               div_s     = '0;
            end
         end
         ST_DEBOUNCE: begin
            if (col_s_r != col_cap_r) begin
               row_idx_s = row_idx_r + 2'd1;
               div_s     = '0;
            end else if (deb_r == DEB_LAST) begin
               key_s = key_code(row_idx_r, col_cap_r);
            end else begin
               deb_s = deb_r + DEB_W'(1);
            end
         end
         ST_PRESSED: begin
            if (col_s_r == 4'hF) deb_s = '0;
            else                 deb_s = deb_r;
         end
         ST_RELEASE: begin
            // A column dropping low again just falls back to PRESSED.
            if (col_s_r != 4'hF) begin
               deb_s = deb_r;
            end else if (deb_r == DEB_LAST) begin
               key_s     = 4'd0;
               row_idx_s = row_idx_r + 2'd1;
               div_s     = '0;
            end else begin
               deb_s = deb_r + DEB_W'(1);
            end
         end
         default: begin
            div_s     = '0;
            deb_s     = '0;
            row_idx_s = 2'd0;
            key_s     = 4'd0;
         end
      endcase
      row_s = ~(4'b0001 << row_idx_s);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_r     <= '0;
         deb_r     <= '0;
         row_idx_r <= 2'd0;
         row_r     <= 4'b1110;
         col_cap_r <= 4'd0;
         key_r     <= 4'd0;
      end else begin
         div_r     <= div_s;
         deb_r     <= deb_s;
         row_idx_r <= row_idx_s;
         row_r     <= row_s;
         col_cap_r <= col_cap_s;
         key_r     <= key_s;
      end
   end
endmodule
